// File: rtl/bcd_to_binary_seq_if.sv
// ============================================================================
// Module : bcd_to_binary_seq_if
// Brief  : Digit-triple input and binary result handshake bundle for
//          bcd_to_binary_seq.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bcd_to_binary_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] bin;
    logic       ovf;
    logic       digit_err;

    modport master (
        output in_valid, hundreds, tens, ones, out_ready,
        input  in_ready, out_valid, bin, ovf, digit_err
    );

    modport slave (
        input  in_valid, hundreds, tens, ones, out_ready,
        output in_ready, out_valid, bin, ovf, digit_err
    );
endinterface

`default_nettype wire

// File: rtl/bcd_to_binary_seq.sv
// ============================================================================
// Module : bcd_to_binary_seq
// Brief  : Sequential 3-digit BCD to 10-bit binary converter (reverse
//          double-dabble, fixed 11-cycle latency). Optional macro
//          DIGIT_CHECK_EN flags digits > 9 and short-cuts to the result.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_to_binary_seq (
    input  wire logic           clk,
    input  wire logic           rst,
    bcd_to_binary_seq_if.slave  bus
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CONVERT = 2'd1;
    localparam logic [1:0] c_DONE    = 2'd2;
    localparam logic [3:0] c_STEPS   = 4'd10;

    logic [1:0]  r_state;
    logic [11:0] r_bcd;
    logic [9:0]  r_acc;
    logic [3:0]  r_cnt;
    logic [9:0]  r_bin;
    logic        r_ovf;

    logic [21:0] w_shift;
    logic [11:0] w_bcd_sh;
    logic [11:0] w_bcd_next;
    logic [9:0]  w_acc_next;
    logic        w_bad;

    // BCD LSB falls into the accumulator MSB on every step
    assign w_shift    = {r_bcd, r_acc} >> 1;
    assign w_bcd_sh   = w_shift[21:10];
    assign w_acc_next = w_shift[9:0];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi = gi + 1) begin : g_nib
            assign w_bcd_next[4*gi +: 4] = (w_bcd_sh[4*gi +: 4] >= 4'd8) ?
                                           (w_bcd_sh[4*gi +: 4] - 4'd3) :
                                            w_bcd_sh[4*gi +: 4];
        end
    endgenerate

`ifdef DIGIT_CHECK_EN
    logic r_digit_err;

    assign w_bad = (bus.hundreds > 4'd9) || (bus.tens > 4'd9) || (bus.ones > 4'd9);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_digit_err <= 1'b0;
        end else if (r_state == c_IDLE && bus.in_valid) begin
            r_digit_err <= w_bad;
        end
    end

    assign bus.digit_err = r_digit_err;
`else
    assign w_bad         = 1'b0;
    assign bus.digit_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_bcd   <= 12'd0;
            r_acc   <= 10'd0;
            r_cnt   <= 4'd0;
            r_bin   <= 10'd0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        r_bcd <= {bus.hundreds, bus.tens, bus.ones};
                        r_acc <= 10'd0;
                        r_cnt <= c_STEPS;
                        if (w_bad) begin
                            r_bin   <= 10'd0;
                            r_ovf   <= 1'b0;
                            r_state <= c_DONE;
                        end else begin
                            r_state <= c_CONVERT;
                        end
                    end
                end
                c_CONVERT: begin
                    r_bcd <= w_bcd_next;
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_bin   <= w_acc_next;
                        r_ovf   <= (w_acc_next > 10'd255);
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == c_IDLE);
    assign bus.out_valid = (r_state == c_DONE);
    assign bus.bin       = r_bin;
    assign bus.ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_binary_seq.sv
// ============================================================================
// Module : tb_bcd_to_binary_seq
// Brief  : Directed self-checking bench for bcd_to_binary_seq.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_to_binary_seq;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    bcd_to_binary_seq_if u_if ();

    bcd_to_binary_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Starts one conversion from IDLE (called #1 after a rising edge) and
    // returns #1 after the edge on which out_valid first appears.
    task automatic run_conv(input string tag, input logic [3:0] h, input logic [3:0] t,
                            input logic [3:0] o, input bit chk_bin, input int exp_bin,
                            input int exp_ovf, input int exp_err, input int exp_lat);
        int lat;
        chk($sformatf("%s_in_ready", tag), int'(u_if.in_ready), 1);
        u_if.in_valid = 1'b1;
        u_if.hundreds = h;
        u_if.tens     = t;
        u_if.ones     = o;
        @(posedge clk); #1;
        u_if.in_valid = 1'b0;
        u_if.hundreds = 4'd7;
        u_if.tens     = 4'd3;
        u_if.ones     = 4'd1;
        chk($sformatf("%s_busy", tag), int'(u_if.in_ready), 0);
        lat = 1;
        while (!u_if.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("%s_lat", tag), lat, exp_lat);
        if (chk_bin) chk($sformatf("%s_bin", tag), int'(u_if.bin), exp_bin);
        chk($sformatf("%s_ovf", tag), int'(u_if.ovf), exp_ovf);
        chk($sformatf("%s_err", tag), int'(u_if.digit_err), exp_err);
    endtask

    task automatic back_to_idle(input string tag);
        @(posedge clk); #1;
        chk($sformatf("%s_idle_rdy", tag), int'(u_if.in_ready), 1);
        chk($sformatf("%s_idle_ov", tag), int'(u_if.out_valid), 0);
    endtask

    initial begin
        n_chk         = 0;
        n_bad         = 0;
        rst           = 1'b1;
        u_if.in_valid = 1'b0;
        u_if.hundreds = 4'd0;
        u_if.tens     = 4'd0;
        u_if.ones     = 4'd0;
        u_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(u_if.in_ready), 1);
        chk("rst_out_valid", int'(u_if.out_valid), 0);
        chk("rst_bin", int'(u_if.bin), 0);
        chk("rst_ovf", int'(u_if.ovf), 0);
        chk("rst_err", int'(u_if.digit_err), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_conv("d225", 4'd2, 4'd2, 4'd5, 1'b1, 225, 0, 0, 11);
        back_to_idle("d225");
        run_conv("d999", 4'd9, 4'd9, 4'd9, 1'b1, 999, 1, 0, 11);
        back_to_idle("d999");
        run_conv("d000", 4'd0, 4'd0, 4'd0, 1'b1, 0, 0, 0, 11);
        back_to_idle("d000");
        run_conv("d256", 4'd2, 4'd5, 4'd6, 1'b1, 256, 1, 0, 11);
        back_to_idle("d256");
        run_conv("d255", 4'd2, 4'd5, 4'd5, 1'b1, 255, 0, 0, 11);
        back_to_idle("d255");
        run_conv("d087", 4'd0, 4'd8, 4'd7, 1'b1, 87, 0, 0, 11);
        back_to_idle("d087");

        // Backpressure: result held, new input ignored while in DONE
        u_if.out_ready = 1'b0;
        run_conv("bp", 4'd1, 4'd2, 4'd3, 1'b1, 123, 0, 0, 11);
        u_if.in_valid = 1'b1;
        u_if.hundreds = 4'd9;
        u_if.tens     = 4'd9;
        u_if.ones     = 4'd9;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_ov", int'(u_if.out_valid), 1);
            chk("bp_hold_rdy", int'(u_if.in_ready), 0);
            chk("bp_hold_bin", int'(u_if.bin), 123);
        end
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b1;
        back_to_idle("bp");

        // Reset on the 5th CONVERT edge discards the conversion
        u_if.in_valid = 1'b1;
        u_if.hundreds = 4'd7;
        u_if.tens     = 4'd7;
        u_if.ones     = 4'd7;
        @(posedge clk); #1;
        u_if.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        u_if.in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        u_if.in_valid = 1'b0;
        chk("mid_rst_rdy", int'(u_if.in_ready), 1);
        chk("mid_rst_ov", int'(u_if.out_valid), 0);
        chk("mid_rst_bin", int'(u_if.bin), 0);
        run_conv("d144", 4'd1, 4'd4, 4'd4, 1'b1, 144, 0, 0, 11);
        back_to_idle("d144");

`ifdef DIGIT_CHECK_EN
        run_conv("bad_dig", 4'd0, 4'd10, 4'd3, 1'b1, 0, 0, 1, 1);
        back_to_idle("bad_dig");
        run_conv("after_bad", 4'd0, 4'd1, 4'd2, 1'b1, 12, 0, 0, 11);
`else
        run_conv("bad_dig", 4'd0, 4'd10, 4'd3, 1'b0, 0, 0, 0, 11);
        back_to_idle("bad_dig");
        run_conv("after_bad", 4'd0, 4'd1, 4'd2, 1'b1, 12, 0, 0, 11);
`endif
        back_to_idle("after_bad");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
